// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, byte-field codes,
// fetch sequencer states and opcode constants.
package cpu_pkg;

    // Instruction word field positions
    localparam int MODE_HI   = 15;
    localparam int MODE_LO   = 14;
    localparam int BYTE_HI   = 13;
    localparam int BYTE_LO   = 12;
    localparam int OPC_HI    = 11;
    localparam int OPC_LO    = 8;
    localparam int OP1_HI    = 7;
    localparam int OP1_LO    = 5;
    localparam int OP2_HI    = 4;
    localparam int OP2_LO    = 2;
    localparam int OPTYPE_HI = 1;
    localparam int OPTYPE_LO = 0;

    // Byte-field codes: how many words the instruction occupies
    localparam logic [1:0] BYTE_ONE_WORD = 2'b01;
    localparam logic [1:0] BYTE_TWO_WORD = 2'b10;

    // Opcode constants shared with the decoder
    localparam logic [3:0] OPC_ADD = 4'h0;
    localparam logic [3:0] OPC_SUB = 4'h1;
    localparam logic [3:0] OPC_XOR = 4'h2;
    localparam logic [3:0] OPC_AND = 4'h3;
    localparam logic [3:0] OPC_MOV = 4'hB;
    localparam logic [3:0] OPC_MVI = 4'hC;
    localparam logic [3:0] OPC_LDA = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH_A = 2'd1,
        ST_FETCH_B = 2'd2,
        ST_PRESENT = 2'd3
    } fetch_state_t;

    // Extract the byte (length) field of an instruction word
    function automatic logic [1:0] byte_field(input logic [15:0] word);
        return word[BYTE_HI:BYTE_LO];
    endfunction

endpackage

// File: rtl/ins_fetch_ctrl_pc_reg.sv
// Program counter: 16-bit, wraps modulo 2^16, load beats increment.
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_addr,
    input  logic        inc,
    output logic [15:0] pc
);

    // PC update: redirect target has priority over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (load)
            pc <= load_addr;
        else if (inc)
            pc <= pc + 16'd1;
    end

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer: drives ROM address from the PC, waits out the
// ROM latency, assembles one/two-word instructions and hands them to the
// decoder over valid/ready. Supports redirect and run/stop.
module ins_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int          ROM_LAT       = 2,
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [1:0]  TWO_WORD_CODE = BYTE_TWO_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_word,
    output logic [15:0] ins_imm,
    output logic        ins_two_word,
    output logic [15:0] ins_pc,
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr,
    output logic        busy
);

    localparam logic [2:0] LAT_LAST = 3'(ROM_LAT - 1);

    fetch_state_t state, next_state;
    logic [2:0]   lat_cnt;
    logic [15:0]  pc;
    logic         lat_done;
    logic         is_two;
    logic         pc_ld;
    logic         pc_inc;
    logic         lat_clr;
    logic         cap_a;
    logic         cap_b;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_ld),
        .load_addr (pc_load_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign rom_addr  = pc;
    assign lat_done  = (lat_cnt == LAT_LAST);
    assign is_two    = (byte_field(rom_data) == TWO_WORD_CODE);
    assign ins_valid = (state == ST_PRESENT);
    assign busy      = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state and control strobes; redirect outranks capture and handoff
    always_comb begin
        next_state = state;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        lat_clr    = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_ld = 1'b1;
                end else if (enable) begin
                    next_state = ST_FETCH_A;
                    lat_clr    = 1'b1;
                end
            end
            ST_FETCH_A: begin
                if (pc_load) begin
                    pc_ld      = 1'b1;
                    lat_clr    = 1'b1;
                    next_state = ST_FETCH_A;
                end else if (lat_done) begin
                    cap_a      = 1'b1;
                    pc_inc     = 1'b1;
                    lat_clr    = 1'b1;
                    next_state = is_two ? ST_FETCH_B : ST_PRESENT;
                end
            end
            ST_FETCH_B: begin
                if (pc_load) begin
                    pc_ld      = 1'b1;
                    lat_clr    = 1'b1;
                    next_state = ST_FETCH_A;
                end else if (lat_done) begin
                    cap_b      = 1'b1;
                    pc_inc     = 1'b1;
                    lat_clr    = 1'b1;
                    next_state = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // A simultaneous handshake is consumed; redirect then wins
                if (pc_load) begin
                    pc_ld      = 1'b1;
                    lat_clr    = 1'b1;
                    next_state = ST_FETCH_A;
                end else if (ins_ready) begin
                    lat_clr    = 1'b1;
                    next_state = enable ? ST_FETCH_A : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // ROM latency counter, runs only while a word is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lat_cnt <= 3'd0;
        else if (lat_clr)
            lat_cnt <= 3'd0;
        else if (state == ST_FETCH_A || state == ST_FETCH_B)
            lat_cnt <= lat_cnt + 3'd1;
    end

    // Instruction holding registers, stable through PRESENT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_word     <= 16'h0000;
            ins_imm      <= 16'h0000;
            ins_two_word <= 1'b0;
            ins_pc       <= 16'h0000;
        end else if (cap_a) begin
            ins_word <= rom_data;
            ins_pc   <= pc;
            if (!is_two) begin
                ins_imm      <= 16'h0000;
                ins_two_word <= 1'b0;
            end
        end else if (cap_b) begin
            ins_imm      <= rom_data;
            ins_two_word <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: scripted per-cycle vector table for the directed
// scenarios, then randomized traffic checked against an instruction-level model.
module tb_ins_fetch_ctrl;

    localparam int ROM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_word;
    logic [15:0] ins_imm;
    logic        ins_two_word;
    logic [15:0] ins_pc;
    logic        pc_load;
    logic [15:0] pc_load_addr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ins_fetch_ctrl #(.ROM_LAT(ROM_LAT), .RESET_PC(16'h0000), .TWO_WORD_CODE(2'b10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .ins_valid    (ins_valid),
        .ins_ready    (ins_ready),
        .ins_word     (ins_word),
        .ins_imm      (ins_imm),
        .ins_two_word (ins_two_word),
        .ins_pc       (ins_pc),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ROM model with a two-cycle read latency: one address register, then array read
    logic [15:0] mem [0:65535];
    logic [15:0] addr_q = 16'h0000;
    always @(posedge clk) addr_q <= rom_addr;
    assign rom_data = mem[addr_q];

    typedef struct {
        logic        en, rdy, ld;
        logic [15:0] ld_addr;
        logic        chk;           // compare instruction fields on this row
        logic        ev, eb, et;
        logic [15:0] ea, ew, ei, ep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic en, logic rdy, logic ld, logic [15:0] la,
                                logic chk, logic ev, logic eb, logic [15:0] ea,
                                logic [15:0] ew, logic [15:0] ei, logic et, logic [15:0] ep);
        vec_t v;
        v.en = en; v.rdy = rdy; v.ld = ld; v.ld_addr = la; v.chk = chk;
        v.ev = ev; v.eb = eb; v.ea = ea; v.ew = ew; v.ei = ei; v.et = et; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " valid"}, {15'd0, ins_valid}, 16'd0);
        chk({tag, " busy"},  {15'd0, busy}, 16'd0);
        chk({tag, " word"},  ins_word, 16'h0000);
        chk({tag, " imm"},   ins_imm, 16'h0000);
        chk({tag, " two"},   {15'd0, ins_two_word}, 16'd0);
        chk({tag, " pc"},    ins_pc, 16'h0000);
        chk({tag, " addr"},  rom_addr, 16'h0000);
    endtask

    // Instruction-level reference state for the random phase
    logic [15:0] mpc;
    logic [15:0] exp_imm;
    logic        exp_two;
    logic        hs;
    logic        pv;
    logic [15:0] sw, si, sp;
    logic        st;
    int          n_hs;

    initial begin
        rst_n = 1'b0; enable = 1'b0; ins_ready = 1'b0; pc_load = 1'b0; pc_load_addr = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h1000;
        mem[16'h0000] = 16'h1B5C;   // MOV
        mem[16'h0001] = 16'h1A21;
        mem[16'h0002] = 16'h1C44;
        mem[16'h0003] = 16'hADCC;   // LDA header
        mem[16'h0004] = 16'h8449;   // LDA address word
        mem[16'h0005] = 16'h1015;   // ADD
        mem[16'h0006] = 16'h1122;
        mem[16'hFFFF] = 16'h2100;   // two-word header at top of memory

        //            en rdy ld addr     chk v  b  rom_addr  word      imm       two  ins_pc
        tbl.push_back(mk(1, 1, 0, 16'h0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000)); // 0 IDLE
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 1, 1, 1, 16'h0001, 16'h1B5C, 16'h0000, 0, 16'h0000)); // 3 MOV
        tbl.push_back(mk(1, 1, 1, 16'h3, 0, 0, 1, 16'h0001, 0, 0, 0, 0));                       // 4 redirect
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0003, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0003, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0004, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0004, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)                                                              // 9-13 stall
            tbl.push_back(mk(1, 0, 0, 16'h0, 1, 1, 1, 16'h0005, 16'hADCC, 16'h8449, 1, 16'h0003));
        tbl.push_back(mk(1, 1, 0, 16'h0, 1, 1, 1, 16'h0005, 16'hADCC, 16'h8449, 1, 16'h0003)); // 14 accept
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0005, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0005, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 1, 1, 1, 16'h0006, 16'h1015, 16'h0000, 0, 16'h0005)); // 17 ADD
        tbl.push_back(mk(1, 1, 1, 16'h3, 0, 0, 1, 16'h0006, 0, 0, 0, 0));                       // 18 redirect
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0003, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0003, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0004, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 16'h5, 0, 0, 1, 16'h0004, 0, 0, 0, 0));                       // 22 load beats capture
        tbl.push_back(mk(0, 1, 0, 16'h0, 0, 0, 1, 16'h0005, 0, 0, 0, 0));                       // 23 enable drop
        tbl.push_back(mk(0, 1, 0, 16'h0, 0, 0, 1, 16'h0005, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 16'h0, 1, 1, 1, 16'h0006, 16'h1015, 16'h0000, 0, 16'h0005)); // 25 still presented
        tbl.push_back(mk(0, 1, 0, 16'h0, 0, 0, 0, 16'h0006, 0, 0, 0, 0));                       // 26 IDLE
        tbl.push_back(mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 16'h0006, 0, 0, 0, 0));                    // 27 load in IDLE
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'hFFFF, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 0, 0));                       // 31 wrapped
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0, 1, 1, 1, 16'h0001, 16'h2100, 16'h1B5C, 1, 16'hFFFF)); // 33 wrap pair
        tbl.push_back(mk(1, 1, 0, 16'h0, 0, 0, 1, 16'h0001, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            enable = tbl[i].en; ins_ready = tbl[i].rdy;
            pc_load = tbl[i].ld; pc_load_addr = tbl[i].ld_addr;
            #1;
            chk($sformatf("row%0d valid", i), {15'd0, ins_valid}, {15'd0, tbl[i].ev});
            chk($sformatf("row%0d busy", i),  {15'd0, busy}, {15'd0, tbl[i].eb});
            chk($sformatf("row%0d rom_addr", i), rom_addr, tbl[i].ea);
            if (tbl[i].chk) begin
                chk($sformatf("row%0d word", i), ins_word, tbl[i].ew);
                chk($sformatf("row%0d imm", i),  ins_imm, tbl[i].ei);
                chk($sformatf("row%0d two", i),  {15'd0, ins_two_word}, {15'd0, tbl[i].et});
                chk($sformatf("row%0d pc", i),   ins_pc, tbl[i].ep);
            end
        end

        // Asynchronous reset in the middle of a fetch
        @(negedge clk);
        pc_load = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midfetch_reset");
        @(negedge clk);
        rst_n = 1'b1; enable = 1'b0;
        #1 chk("post_reset busy", {15'd0, busy}, 16'd0);

        // Randomized phase: fresh ROM contents, model tracks instructions not cycles
        rst_n = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mpc = 16'h0000; pv = 1'b0; n_hs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            enable    = ($urandom_range(0, 9) != 0);
            ins_ready = 1'($urandom_range(0, 1));
            pc_load   = ($urandom_range(0, 24) == 0);
            pc_load_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            #1;
            // Presented instruction must hold until accepted or redirected
            if (pv && ins_valid) begin
                chk("hold word", ins_word, sw);
                chk("hold imm", ins_imm, si);
                chk("hold pc", ins_pc, sp);
                chk("hold two", {15'd0, ins_two_word}, {15'd0, st});
            end
            if (pv && !ins_valid) begin
                n_vec++; n_err++;
                $display("FAIL valid_dropped: got 0, expected 1 at cycle %0d", c);
            end
            hs = ins_valid && ins_ready;
            if (hs) begin
                n_hs++;
                exp_two = (mem[mpc][13:12] == 2'b10);
                exp_imm = exp_two ? mem[16'(mpc + 16'd1)] : 16'h0000;
                chk("rand pc", ins_pc, mpc);
                chk("rand word", ins_word, mem[mpc]);
                chk("rand imm", ins_imm, exp_imm);
                chk("rand two", {15'd0, ins_two_word}, {15'd0, exp_two});
                mpc = mpc + (exp_two ? 16'd2 : 16'd1);
            end
            if (pc_load) mpc = pc_load_addr;
            pv = ins_valid && !hs && !pc_load;
            sw = ins_word; si = ins_imm; sp = ins_pc; st = ins_two_word;
        end
        n_vec++;
        if (n_hs < 50) begin
            n_err++;
            $display("FAIL rand_progress: got %0d handoffs, expected at least 50", n_hs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ins_fetch_ctrl.md
Name: ins_fetch_ctrl

Overview:
Instruction fetch sequencer for the 16-bit CPU. It owns the program counter and drives the instruction ROM address. It waits out the ROM's fixed read latency and assembles one- or two-word instructions (MVI/LDA carry a second immediate/address word). It presents each complete instruction to the decoder over a valid/ready handshake, and supports redirect (jump/branch PC load) and run/stop control.

Parameters:
ROM_LAT, 2, cycles from rom_addr change to valid rom_data (legal 1..7)
RESET_PC, 16'h0000, PC value after reset
TWO_WORD_CODE, 2'b10, value of the instruction byte field [13:12] that marks a two-word instruction

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; low = stop after current instruction is handed off
rom_addr  out  16  address to instruction ROM
rom_data  in  16  instruction ROM read data, valid ROM_LAT cycles after rom_addr
ins_valid  out  1  complete instruction available
ins_ready  in  1  decoder accepts instruction
ins_word  out  16  first instruction word (mode/byte/opcode/op1/op2/optype)
ins_imm  out  16  second word; 16'h0000 for one-word instructions
ins_two_word  out  1  instruction had a second word
ins_pc  out  16  address of ins_word
pc_load  in  1  redirect request, one-cycle pulse
pc_load_addr  in  16  redirect target
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, FETCH_A (first word), FETCH_B (second word), PRESENT.
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, rom_addr=RESET_PC, lat_cnt=0. Outputs: ins_valid=0, ins_word=0, ins_imm=0, ins_two_word=0, ins_pc=0, busy=0.
- Reset mid-fetch aborts the fetch immediately; no partial instruction survives.
- IDLE: rom_addr=pc. enable=1 -> FETCH_A next edge, lat_cnt cleared.
- FETCH_A: rom_addr=pc, lat_cnt increments each cycle.
  - On the edge where lat_cnt==ROM_LAT-1: capture ins_word=rom_data, ins_pc=pc, pc=pc+1.
  - If rom_data[13:12]==TWO_WORD_CODE: go to FETCH_B.
  - Else: ins_imm=0, ins_two_word=0, go to PRESENT.
- FETCH_B: rom_addr=pc, same counting. At ROM_LAT-1: ins_imm=rom_data, ins_two_word=1, pc=pc+1, go to PRESENT.
- Latency: ins_valid rises ROM_LAT cycles after FETCH_A entry for one-word instructions, 2*ROM_LAT cycles for two-word.
- PRESENT: ins_valid=1. All ins_* outputs are stable until the handshake.
  - ins_valid && ins_ready at an edge: with enable=1 -> FETCH_A (zero-bubble restart); with enable=0 -> IDLE.
  - ins_valid never drops without a handshake unless pc_load or reset occurs.
- PC arithmetic: 16-bit modulo. pc=16'hFFFF increments to 16'h0000. A two-word instruction at FFFF takes its second word from 0000.
- pc_load, any non-IDLE state: at that edge pc=pc_load_addr, lat_cnt=0, ins_valid=0, state=FETCH_A. Any in-flight word is discarded.
- pc_load in PRESENT with ins_ready=1 in the same cycle: the handshake completes (instruction consumed), then the redirect applies.
- pc_load in IDLE: pc=pc_load_addr, remain IDLE.
- pc_load has priority over the normal FETCH_A/FETCH_B capture in the same cycle.
- enable falling mid-fetch: the fetch completes and the instruction is presented. Stop occurs only after handoff; it is never torn.
- busy = (state != IDLE).

Decomposition:
- Shared package cpu_pkg:
  - instruction field positions: MODE [15:14], BYTE [13:12], OPC [11:8], OP1 [7:5], OP2 [4:2], OPTYPE [1:0]
  - byte-field codes: ONE_WORD 2'b01, TWO_WORD 2'b10
  - fetch state enum
  - opcode constants: MOV/MVI/LDA/ADD/SUB/XOR/AND, for the decoder and this block
- One sub-module is natural: pc_reg (16-bit PC with load/increment, async reset to RESET_PC). Everything else stays in this module.

Test Plan:
- ROM model (ROM_LAT=2) holds addr0=16'h1B5C (MOV). Release reset, enable=1, ins_ready=1 -> ins_valid at cycle 2 after FETCH_A entry, ins_word=1B5C, ins_pc=0000, ins_two_word=0, ins_imm=0000; next FETCH_A at pc=0001.
- addr3=16'hADCC, addr4=16'h8449 (LDA), pc_load to 0003 -> ins_valid 4 cycles after redirect, ins_word=ADCC, ins_imm=8449, ins_two_word=1, ins_pc=0003; pc=0005 afterwards.
- ins_ready held 0 for 5 cycles in PRESENT -> ins_valid and all ins_* constant; on ready=1 advance exactly one instruction with no bubble.
- pc_load(0x0005) asserted in FETCH_B of the LDA -> no ins_valid for the LDA; next presented ins_pc=0005, ins_word=16'h1015 (ADD).
- pc_load_addr=FFFF, ROM[FFFF]=two-word header, ROM[0000]=16'h1B5C -> ins_imm=1B5C, then pc=0001.
- rst_n pulsed low during FETCH_A; separately, enable dropped during FETCH_A -> reset: all outputs return to reset values asynchronously and busy=0; enable drop: the instruction is still presented and after the handshake state=IDLE, busy=0.
